sata_oob: RTL

Out-of-band (OOB) link bring-up sequencer for the SATA host PHY. It waits for the transceiver power-up/reset sequencer to report completion, then runs the host OOB handshake: COMRESET, await COMINIT, COMWAKE, await COMWAKE, D10.2, then ALIGN/SYNC exchange. It retries on timeout and requests a full PHY re-initialisation after repeated failures. It sits between the PHY init sequencer and the link layer, and drives the GTX OOB and TX-control pins.

---
 rtl/sata_oob.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sata_oob.sv
// Host-side SATA out-of-band bring-up sequencer: COMRESET/COMWAKE exchange,
// D10.2 and ALIGN/SYNC handover, with per-phase timeout and PHY re-init request.
module sata_oob #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd132000,
  parameter logic [3:0]  MAX_RETRIES    = 4'd8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_phy_ready,
  input  logic       i_tx_comfinish,
  input  logic       i_rx_cominit,
  input  logic       i_rx_comwake,
  input  logic       i_rx_align,
  input  logic       i_rx_primitive,
  output logic       o_tx_cominit,
  output logic       o_tx_comwake,
  output logic       o_tx_elecidle,
  output logic       o_tx_d10,
  output logic       o_tx_align,
  output logic       o_link_up,
  output logic       o_err,
  output logic       o_phy_reset,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_COMRESET     = 3'd1,
    ST_WAIT_COMINIT = 3'd2,
    ST_COMWAKE      = 3'd3,
    ST_WAIT_COMWAKE = 3'd4,
    ST_SEND_D10     = 3'd5,
    ST_SEND_ALIGN   = 3'd6,
    ST_READY        = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] phase_cnt_q, phase_cnt_d;
  logic [3:0]  retry_q, retry_d, retry_inc;
  logic [1:0]  sync_cnt_q, sync_cnt_d;
  logic        enter, timeout, give_up, counted, after_cominit, is_sync;

  logic tx_cominit_q, tx_cominit_d;
  logic tx_comwake_q, tx_comwake_d;
  logic tx_elecidle_q, tx_elecidle_d;
  logic tx_d10_q, tx_d10_d;
  logic tx_align_q, tx_align_d;
  logic link_up_q, link_up_d;
  logic err_q, err_d;
  logic phy_reset_q, phy_reset_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      phase_cnt_q   <= '0;
      retry_q       <= '0;
      sync_cnt_q    <= '0;
      tx_cominit_q  <= 1'b0;
      tx_comwake_q  <= 1'b0;
      tx_elecidle_q <= 1'b1;
      tx_d10_q      <= 1'b0;
      tx_align_q    <= 1'b0;
      link_up_q     <= 1'b0;
      err_q         <= 1'b0;
      phy_reset_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_cnt_q   <= phase_cnt_d;
      retry_q       <= retry_d;
      sync_cnt_q    <= sync_cnt_d;
      tx_cominit_q  <= tx_cominit_d;
      tx_comwake_q  <= tx_comwake_d;
      tx_elecidle_q <= tx_elecidle_d;
      tx_d10_q      <= tx_d10_d;
      tx_align_q    <= tx_align_d;
      link_up_q     <= link_up_d;
      err_q         <= err_d;
      phy_reset_q   <= phy_reset_d;
    end
  end

  // enter marks any taken transition, including timeout re-entry of COMRESET,
  // so the phase counter restarts and the entry pulses fire again.
  always_comb begin
    state_d       = state_q;
    retry_d       = retry_q;
    enter         = 1'b0;
    timeout       = 1'b0;
    give_up       = 1'b0;
    retry_inc     = retry_q + 4'd1;
    counted       = (state_q != ST_IDLE) && (state_q != ST_READY);
    after_cominit = state_q inside {ST_COMWAKE, ST_WAIT_COMWAKE, ST_SEND_D10,
                                    ST_SEND_ALIGN, ST_READY};
    is_sync       = i_rx_primitive && !i_rx_align;
    if (!i_phy_ready) begin
      state_d = ST_IDLE;
      retry_d = '0;
      enter   = (state_q != ST_IDLE);
    end else if (counted && (phase_cnt_q == TIMEOUT_CYCLES - 20'd1)) begin
      timeout = 1'b1;
      enter   = 1'b1;
      if (retry_inc == MAX_RETRIES) begin
        give_up = 1'b1;
        retry_d = '0;
        state_d = ST_IDLE;
      end else begin
        retry_d = retry_inc;
        state_d = ST_COMRESET;
      end
    end else if (after_cominit && i_rx_cominit) begin
      state_d = ST_COMRESET;
      enter   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_COMRESET;
          enter   = 1'b1;
        end
        ST_COMRESET: if (i_tx_comfinish) begin
          state_d = ST_WAIT_COMINIT;
          enter   = 1'b1;
        end
        ST_WAIT_COMINIT: if (i_rx_cominit) begin
          state_d = ST_COMWAKE;
          enter   = 1'b1;
        end
        ST_COMWAKE: if (i_tx_comfinish) begin
          state_d = ST_WAIT_COMWAKE;
          enter   = 1'b1;
        end
        ST_WAIT_COMWAKE: if (i_rx_comwake) begin
          state_d = ST_SEND_D10;
          enter   = 1'b1;
        end
        ST_SEND_D10: if (i_rx_align) begin
          state_d = ST_SEND_ALIGN;
          enter   = 1'b1;
        end
        ST_SEND_ALIGN: if (is_sync && (sync_cnt_q == 2'd2)) begin
          state_d = ST_READY;
          enter   = 1'b1;
        end
        ST_READY: retry_d = '0;
        default: ;
      endcase
    end
    phase_cnt_d = (enter || !counted) ? 20'd0 : phase_cnt_q + 20'd1;
    sync_cnt_d  = (!enter && (state_q == ST_SEND_ALIGN) && is_sync) ? sync_cnt_q + 2'd1 : 2'd0;
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    tx_cominit_d  = enter && (state_d == ST_COMRESET);
    tx_comwake_d  = enter && (state_d == ST_COMWAKE);
    tx_elecidle_d = state_d inside {ST_IDLE, ST_COMRESET, ST_WAIT_COMINIT,
                                    ST_COMWAKE, ST_WAIT_COMWAKE};
    tx_d10_d      = (state_d == ST_SEND_D10);
    tx_align_d    = (state_d == ST_SEND_ALIGN);
    link_up_d     = (state_d == ST_READY);
    err_d         = timeout;
    phy_reset_d   = give_up;
  end

  assign o_tx_cominit  = tx_cominit_q;
  assign o_tx_comwake  = tx_comwake_q;
  assign o_tx_elecidle = tx_elecidle_q;
  assign o_tx_d10      = tx_d10_q;
  assign o_tx_align    = tx_align_q;
  assign o_link_up     = link_up_q;
  assign o_err         = err_q;
  assign o_phy_reset   = phy_reset_q;
  assign o_state       = state_q;

endmodule
